// File: rtl/sbus_pkg.sv
// Shared types and default widths for the serial-bus split target port.
package sbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_ADDR,
    ST_RX_DATA,
    ST_ISSUE,
    ST_WAIT_RESP,
    ST_TX_DATA,
    ST_DONE
  } state_e;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 8;

  // Serial bits are only consumed while a request is still being assembled.
  function automatic logic accepts_bits(input state_e s);
    return (s == ST_IDLE) || (s == ST_RX_ADDR) || (s == ST_RX_DATA);
  endfunction

endpackage

// File: rtl/split_target_port_if.sv
// Serial bus side of the split target port: bit-serial request in, bit-serial read data and status out.
interface split_target_port_if;

  logic bus_valid;
  logic bus_mode;
  logic bus_bit;
  logic bus_ready;
  logic bus_rdata_bit;
  logic bus_rdata_valid;
  logic bus_ack;
  logic bus_split;
  logic bus_err;

  modport master (
    output bus_valid, bus_mode, bus_bit,
    input  bus_ready, bus_rdata_bit, bus_rdata_valid, bus_ack, bus_split, bus_err
  );

  modport slave (
    input  bus_valid, bus_mode, bus_bit,
    output bus_ready, bus_rdata_bit, bus_rdata_valid, bus_ack, bus_split, bus_err
  );

endinterface

// File: rtl/sbus_shift_reg.sv
// Right-shifting register with parallel load: serial data enters at the MSB so LSB-first streams
// assemble in place, and bit 0 is the next bit to leave.
module sbus_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic [WIDTH-1:0] par_out
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_val;
    end else if (shift_en) begin
      sr_d = {ser_in, sr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign par_out = sr_q;

endmodule

// File: rtl/split_target_port.sv
// Serial-bus target port: deserialises address/write data, issues one parallel request to the
// target, and handles ack, split (deferred read), timeout and serial read-data return.
module split_target_port
  import sbus_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  split_target_port_if.slave    bus,
  output logic [ADDR_WIDTH-1:0] target_addr_in,
  output logic                  target_addr_in_valid,
  output logic [DATA_WIDTH-1:0] target_data_in,
  output logic                  target_data_in_valid,
  output logic                  target_rw,
  input  logic [DATA_WIDTH-1:0] target_data_out,
  input  logic                  target_data_out_valid,
  input  logic                  target_ack,
  input  logic                  target_split_ack,
  input  logic                  target_ready
);

  localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TMO_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             frozen_q, frozen_d;
  logic             is_write_q, is_write_d;
  logic             req_q, req_d;
  logic             wreq_q, wreq_d;
  logic             rw_q, rw_d;
  logic             ack_q, ack_d;
  logic             split_q, split_d;
  logic             err_q, err_d;
  logic             rdv_q, rdv_d;
  logic             ready_q, ready_d;

  logic             addr_shift, data_shift, tx_load, tx_shift;
  logic [DATA_WIDTH-1:0] tx_par;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    frozen_d   = frozen_q;
    is_write_d = is_write_q;
    req_d      = 1'b0;
    wreq_d     = 1'b0;
    ack_d      = 1'b0;
    split_d    = 1'b0;
    err_d      = 1'b0;
    addr_shift = 1'b0;
    data_shift = 1'b0;
    tx_load    = 1'b0;
    tx_shift   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.bus_valid) begin
          is_write_d = bus.bus_mode;
          addr_shift = 1'b1;
          bit_cnt_d  = CNT_W'(1);
          frozen_d   = 1'b0;
          state_d    = ST_RX_ADDR;
        end
      end
      ST_RX_ADDR: begin
        if (bus.bus_valid) begin
          addr_shift = 1'b1;
          if (bit_cnt_q == ADDR_LAST) begin
            bit_cnt_d = '0;
            state_d   = is_write_q ? ST_RX_DATA : ST_ISSUE;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_RX_DATA: begin
        if (bus.bus_valid) begin
          data_shift = 1'b1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = ST_ISSUE;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_ISSUE: begin
        if (target_ready) begin
          req_d     = 1'b1;
          wreq_d    = is_write_q;
          tmo_cnt_d = '0;
          frozen_d  = 1'b0;
          state_d   = ST_WAIT_RESP;
        end
      end
      ST_WAIT_RESP: begin
        // An ack always takes priority over a split request in the same cycle.
        if (target_ack) begin
          if (is_write_q) begin
            ack_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (target_data_out_valid) begin
            tx_load   = 1'b1;
            bit_cnt_d = '0;
            state_d   = ST_TX_DATA;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (!is_write_q && target_split_ack && !frozen_q) begin
          split_d  = 1'b1;
          frozen_d = 1'b1;
        end else if (!frozen_q) begin
          if (tmo_cnt_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
        end
      end
      ST_TX_DATA: begin
        tx_shift = 1'b1;
        if (bit_cnt_q == DATA_LAST) begin
          bit_cnt_d = '0;
          ack_d     = 1'b1;
          state_d   = ST_DONE;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rw_d    = (state_d == ST_WAIT_RESP || state_d == ST_TX_DATA || state_d == ST_DONE) ?
              is_write_q : 1'b0;
    rdv_d   = (state_d == ST_TX_DATA);
    ready_d = accepts_bits(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      frozen_q   <= 1'b0;
      is_write_q <= 1'b0;
      req_q      <= 1'b0;
      wreq_q     <= 1'b0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      split_q    <= 1'b0;
      err_q      <= 1'b0;
      rdv_q      <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      frozen_q   <= frozen_d;
      is_write_q <= is_write_d;
      req_q      <= req_d;
      wreq_q     <= wreq_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      split_q    <= split_d;
      err_q      <= err_d;
      rdv_q      <= rdv_d;
      ready_q    <= ready_d;
    end
  end

  sbus_shift_reg #(.WIDTH(ADDR_WIDTH)) u_addr_sr (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_val ('0),
    .shift_en (addr_shift),
    .ser_in   (bus.bus_bit),
    .par_out  (target_addr_in)
  );

  sbus_shift_reg #(.WIDTH(DATA_WIDTH)) u_data_sr (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_val ('0),
    .shift_en (data_shift),
    .ser_in   (bus.bus_bit),
    .par_out  (target_data_in)
  );

  sbus_shift_reg #(.WIDTH(DATA_WIDTH)) u_tx_sr (
    .clk      (clk),
    .rst      (rst),
    .load     (tx_load),
    .load_val (target_data_out),
    .shift_en (tx_shift),
    .ser_in   (1'b0),
    .par_out  (tx_par)
  );

  // Only bit 0 of the TX register is ever presented on the bus.
  logic unused_tx_hi;
  assign unused_tx_hi = ^tx_par[DATA_WIDTH-1:1];

  assign target_addr_in_valid = req_q;
  assign target_data_in_valid = wreq_q;
  assign target_rw            = rw_q;
  assign bus.bus_ready        = ready_q;
  assign bus.bus_rdata_valid  = rdv_q;
  assign bus.bus_rdata_bit    = rdv_q & tx_par[0];
  assign bus.bus_ack          = ack_q;
  assign bus.bus_split        = split_q;
  assign bus.bus_err          = err_q;

endmodule

// File: tb/tb_split_target_port.sv
// Directed bench for split_target_port: a monitor collects target requests and read bytes into
// queues that are checked against expectations pushed when each transaction is driven.
module tb_split_target_port;

  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int TMO = 64;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          rw;
    logic          dv;
  } req_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] target_addr_in;
  logic          target_addr_in_valid;
  logic [DW-1:0] target_data_in;
  logic          target_data_in_valid;
  logic          target_rw;
  logic [DW-1:0] target_data_out = '0;
  logic          target_data_out_valid = 1'b0;
  logic          target_ack = 1'b0;
  logic          target_split_ack = 1'b0;
  logic          target_ready = 1'b1;

  split_target_port_if bif ();

  split_target_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .bus                   (bif.slave),
    .target_addr_in        (target_addr_in),
    .target_addr_in_valid  (target_addr_in_valid),
    .target_data_in        (target_data_in),
    .target_data_in_valid  (target_data_in_valid),
    .target_rw             (target_rw),
    .target_data_out       (target_data_out),
    .target_data_out_valid (target_data_out_valid),
    .target_ack            (target_ack),
    .target_split_ack      (target_split_ack),
    .target_ready          (target_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int n_req = 0, n_ack = 0, n_split = 0, n_err = 0;
  int rd_n = 0;
  logic [DW-1:0] rd_acc = '0;
  req_t exp_req[$], obs_req[$];
  logic [DW-1:0] exp_rd[$], obs_rd[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Bus/target monitor, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (target_addr_in_valid) begin
        n_req++;
        obs_req.push_back(req_t'{a: target_addr_in, d: target_data_in,
                                 rw: target_rw, dv: target_data_in_valid});
      end
      if (bif.bus_ack)   n_ack++;
      if (bif.bus_split) n_split++;
      if (bif.bus_err)   n_err++;
      if (bif.bus_rdata_valid) begin
        rd_acc = {bif.bus_rdata_bit, rd_acc[DW-1:1]};
        rd_n++;
        if (rd_n == DW) begin
          obs_rd.push_back(rd_acc);
          rd_n = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic mode, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input int gap);
    for (int i = 0; i < AW; i++) begin
      if (i > 0) repeat (gap) tick();
      bif.bus_valid = 1'b1;
      bif.bus_mode  = mode;
      bif.bus_bit   = addr[i];
      tick();
      bif.bus_valid = 1'b0;
    end
    if (mode) begin
      for (int i = 0; i < DW; i++) begin
        if (gap > 0) repeat (gap) tick();
        bif.bus_valid = 1'b1;
        bif.bus_bit   = data[i];
        tick();
        bif.bus_valid = 1'b0;
      end
    end
    bif.bus_bit = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int i;
    i = 0;
    while (!target_addr_in_valid && i < 40) begin
      tick();
      i++;
    end
    chk(tag, target_addr_in_valid, 1);
  endtask

  task automatic chk_req(input string tag);
    req_t e, o;
    chk({tag, "_present"}, obs_req.size() > 0 && exp_req.size() > 0, 1);
    if (obs_req.size() > 0 && exp_req.size() > 0) begin
      e = exp_req.pop_front();
      o = obs_req.pop_front();
      chk({tag, "_addr"}, o.a, e.a);
      chk({tag, "_rw"}, o.rw, e.rw);
      chk({tag, "_dvalid"}, o.dv, e.dv);
      if (e.rw) chk({tag, "_data"}, o.d, e.d);
    end
  endtask

  task automatic chk_rd(input string tag);
    chk({tag, "_present"}, obs_rd.size() > 0 && exp_rd.size() > 0, 1);
    if (obs_rd.size() > 0 && exp_rd.size() > 0) chk(tag, obs_rd.pop_front(), exp_rd.pop_front());
  endtask

  // Called in the cycle after the latching target_ack: DW serial bits, then bus_ack.
  task automatic expect_serial(input logic [DW-1:0] d, input string tag);
    for (int i = 0; i < DW; i++) begin
      chk({tag, "_rvalid"}, bif.bus_rdata_valid, 1);
      chk({tag, "_rbit"}, bif.bus_rdata_bit, d[i]);
      tick();
    end
    chk({tag, "_ack"}, bif.bus_ack, 1);
    chk({tag, "_rvalid_end"}, bif.bus_rdata_valid, 0);
    tick();
    chk({tag, "_ack_once"}, bif.bus_ack, 0);
    chk({tag, "_ready"}, bif.bus_ready, 1);
  endtask

  task automatic write_ack(input string tag);
    tick();
    target_ack = 1'b1;
    tick();
    target_ack = 1'b0;
    chk({tag, "_bus_ack"}, bif.bus_ack, 1);
    tick();
    chk({tag, "_ack_once"}, bif.bus_ack, 0);
    chk({tag, "_ready"}, bif.bus_ready, 1);
  endtask

  initial begin
    int snap, c0, i;
    bif.bus_valid = 1'b0;
    bif.bus_mode  = 1'b0;
    bif.bus_bit   = 1'b0;
    repeat (2) tick();
    chk("rst_ready", bif.bus_ready, 1);
    chk("rst_req", target_addr_in_valid, 0);
    chk("rst_outs", {bif.bus_ack, bif.bus_split, bif.bus_err, bif.bus_rdata_valid,
                     bif.bus_rdata_bit, target_rw, target_data_in_valid}, 0);
    chk("rst_addr", target_addr_in, 0);
    rst = 1'b0;
    tick();

    // Write 0x0005 / 0xA5, ack one cycle after the request.
    exp_req.push_back(req_t'{a: 16'h0005, d: 8'hA5, rw: 1'b1, dv: 1'b1});
    send(1'b1, 16'h0005, 8'hA5, 0);
    chk("wr_busy", bif.bus_ready, 0);
    wait_req("wr_req");
    tick();
    chk("wr_req_pulse", target_addr_in_valid, 0);
    chk("wr_rw_hold", target_rw, 1);
    target_ack = 1'b1;
    tick();
    target_ack = 1'b0;
    chk("wr_bus_ack", bif.bus_ack, 1);
    tick();
    chk("wr_ack_once", bif.bus_ack, 0);
    chk_req("wr");

    // Read 0x000C with split, ack 4 cycles later carrying 0x3C.
    exp_req.push_back(req_t'{a: 16'h000C, d: 8'h00, rw: 1'b0, dv: 1'b0});
    exp_rd.push_back(8'h3C);
    snap = n_split;
    send(1'b0, 16'h000C, 8'h00, 0);
    wait_req("rd_req");
    tick();
    target_split_ack = 1'b1;
    tick();
    target_split_ack = 1'b0;
    chk("rd_split", bif.bus_split, 1);
    repeat (3) tick();
    target_ack = 1'b1;
    target_data_out_valid = 1'b1;
    target_data_out = 8'h3C;
    tick();
    target_ack = 1'b0;
    target_data_out_valid = 1'b0;
    expect_serial(8'h3C, "rd");
    chk("rd_split_count", n_split - snap, 1);
    chk_req("rd");
    chk_rd("rd_byte");

    // Address bits separated by 3-cycle gaps.
    exp_req.push_back(req_t'{a: 16'h1234, d: 8'h5A, rw: 1'b1, dv: 1'b1});
    send(1'b1, 16'h1234, 8'h5A, 3);
    wait_req("gap_req");
    write_ack("gap");
    chk_req("gap");

    // Target not ready for 5 cycles while in issue.
    target_ready = 1'b0;
    snap = n_req;
    exp_req.push_back(req_t'{a: 16'h00F0, d: 8'h11, rw: 1'b1, dv: 1'b1});
    send(1'b1, 16'h00F0, 8'h11, 0);
    repeat (5) tick();
    chk("nrdy_no_req", n_req - snap, 0);
    target_ready = 1'b1;
    tick();
    chk("nrdy_req", target_addr_in_valid, 1);
    write_ack("nrdy");
    chk("nrdy_req_count", n_req - snap, 1);
    chk_req("nrdy");

    // Write with no target response: timeout.
    exp_req.push_back(req_t'{a: 16'h0042, d: 8'h77, rw: 1'b1, dv: 1'b1});
    snap = n_err;
    send(1'b1, 16'h0042, 8'h77, 0);
    wait_req("tmo_req");
    c0 = cyc;
    i = 0;
    while (!bif.bus_err && i < 3 * TMO) begin
      tick();
      i++;
    end
    chk("tmo_err_seen", bif.bus_err, 1);
    chk("tmo_latency", cyc - c0, TMO);
    chk("tmo_ready", bif.bus_ready, 1);
    tick();
    chk("tmo_err_once", n_err - snap, 1);
    chk_req("tmo");

    // Split read stays frozen past TIMEOUT, then ack without data -> bus_err.
    exp_req.push_back(req_t'{a: 16'h0301, d: 8'h00, rw: 1'b0, dv: 1'b0});
    snap = n_err;
    send(1'b0, 16'h0301, 8'h00, 0);
    wait_req("frz_req");
    target_split_ack = 1'b1;
    tick();
    target_split_ack = 1'b0;
    repeat (TMO + 8) tick();
    chk("frz_no_err", n_err - snap, 0);
    target_ack = 1'b1;
    tick();
    target_ack = 1'b0;
    chk("frz_err", bif.bus_err, 1);
    chk("frz_ready", bif.bus_ready, 1);
    chk_req("frz");

    // Split and ack together: ack wins, no split.
    exp_req.push_back(req_t'{a: 16'h0007, d: 8'h00, rw: 1'b0, dv: 1'b0});
    exp_rd.push_back(8'h81);
    snap = n_split;
    send(1'b0, 16'h0007, 8'h00, 0);
    wait_req("both_req");
    target_ack = 1'b1;
    target_split_ack = 1'b1;
    target_data_out_valid = 1'b1;
    target_data_out = 8'h81;
    tick();
    target_ack = 1'b0;
    target_split_ack = 1'b0;
    target_data_out_valid = 1'b0;
    chk("both_no_split", bif.bus_split, 0);
    expect_serial(8'h81, "both");
    chk("both_split_count", n_split - snap, 0);
    chk_req("both");
    chk_rd("both_byte");

    // Reset after 7 address bits discards the transaction.
    snap = n_req;
    for (int k = 0; k < 7; k++) begin
      bif.bus_valid = 1'b1;
      bif.bus_mode  = 1'b1;
      bif.bus_bit   = k[0];
      tick();
    end
    bif.bus_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_rst_ready", bif.bus_ready, 1);
    chk("mid_rst_addr", target_addr_in, 0);
    rst = 1'b0;
    repeat (4) tick();
    chk("mid_rst_no_req", n_req - snap, 0);
    exp_req.push_back(req_t'{a: 16'h0ABC, d: 8'h00, rw: 1'b0, dv: 1'b0});
    exp_rd.push_back(8'h96);
    send(1'b0, 16'h0ABC, 8'h00, 0);
    wait_req("post_rst_req");
    target_ack = 1'b1;
    target_data_out_valid = 1'b1;
    target_data_out = 8'h96;
    tick();
    target_ack = 1'b0;
    target_data_out_valid = 1'b0;
    expect_serial(8'h96, "post_rst");
    chk_req("post_rst");
    chk_rd("post_rst_byte");

    chk("leftover_req", obs_req.size(), 0);
    chk("leftover_rd", obs_rd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/split_target_port.md
SPLIT_TARGET_PORT -- requirements
Module: split_target_port

Interface
REQ-001 Parameters (name, default, meaning), one per line: ADDR_WIDTH, 16, target address bits. DATA_WIDTH, 8, data bits. TIMEOUT, 64, response-wait limit in cycles (TIMEOUT >= 2).
REQ-002 clk  in  1  sole clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 bus_valid  in  1  serial bit present this cycle.
REQ-005 bus_mode  in  1  sampled on first valid bit of a transaction; 1=write, 0=read.
REQ-006 bus_bit  in  1  serial address/write-data bit, LSB first.
REQ-007 bus_ready  out  1  port can accept serial bits.
REQ-008 bus_rdata_bit  out  1  serial read-data bit, LSB first.
REQ-009 bus_rdata_valid  out  1  bus_rdata_bit qualifier.
REQ-010 bus_ack  out  1  one-cycle transaction-complete pulse.
REQ-011 bus_split  out  1  one-cycle pulse: read deferred by target.
REQ-012 bus_err  out  1  one-cycle timeout pulse.
REQ-013 target_addr_in  out  ADDR_WIDTH  assembled address.
REQ-014 target_addr_in_valid  out  1  one-cycle request pulse.
REQ-015 target_data_in  out  DATA_WIDTH  assembled write data.
REQ-016 target_data_in_valid  out  1  asserted with request pulse on writes only.
REQ-017 target_rw  out  1  1=write; held stable from request pulse until return to ST_IDLE.
REQ-018 target_data_out  in  DATA_WIDTH  read data from target.
REQ-019 target_data_out_valid  in  1  read data qualifier.
REQ-020 target_ack  in  1  target completion.
REQ-021 target_split_ack  in  1  target deferred the read.
REQ-022 target_ready  in  1  target can accept a request.

Function
REQ-023 States: ST_IDLE, ST_RX_ADDR, ST_RX_DATA, ST_ISSUE, ST_WAIT_RESP, ST_TX_DATA, ST_DONE.
REQ-024 bus_ready = 1 only in ST_IDLE, ST_RX_ADDR, ST_RX_DATA; bus bits at other times are ignored.
REQ-025 ST_IDLE: bus_valid -> capture bus_mode and bit 0 of address, bit counter = 1, go ST_RX_ADDR.
REQ-026 Only cycles with bus_valid=1 advance the bit counter; gaps hold state indefinitely.
REQ-027 After address bit ADDR_WIDTH-1: write -> ST_RX_DATA (counter cleared); read -> ST_ISSUE.
REQ-028 After data bit DATA_WIDTH-1 -> ST_ISSUE.
REQ-029 ST_ISSUE: while target_ready=0, hold with no pulse; when target_ready=1, pulse target_addr_in_valid (plus target_data_in_valid if write) for exactly one cycle, go ST_WAIT_RESP, timeout counter = 0.
REQ-030 ST_WAIT_RESP write: target_ack -> bus_ack pulse next cycle, ST_IDLE.
REQ-031 ST_WAIT_RESP read: target_split_ack -> bus_split pulse and timeout counter frozen until return to ST_IDLE; target_ack with target_data_out_valid -> latch data, ST_TX_DATA.
REQ-032 target_ack without target_data_out_valid on a read -> bus_err pulse, ST_IDLE.
REQ-033 Simultaneous target_split_ack and target_ack -> target_ack wins; no bus_split.
REQ-034 Timeout counter increments each unfrozen ST_WAIT_RESP cycle; reaching TIMEOUT-1 with no ack -> bus_err pulse, ST_IDLE.
REQ-035 ST_TX_DATA: emit DATA_WIDTH bits LSB first, one per cycle, bus_rdata_valid=1 continuously, then ST_DONE.
REQ-036 ST_DONE: bus_ack pulse one cycle, ST_IDLE; earliest new transaction accepted the following cycle.
REQ-037 Read latency: first bus_rdata bit appears the cycle after the latching target_ack.

Reset
REQ-038 rst=1 at any clock edge, including mid-transaction, forces ST_IDLE, clears counters and shift registers, and drives all outputs 0 except bus_ready=1.
REQ-039 A partially received transaction is discarded at reset; no target pulse is emitted.

Structure
REQ-040 Package sbus_pkg holds the state enum and the default ADDR_WIDTH/DATA_WIDTH constants.
REQ-041 Sub-module sbus_shift_reg (parameterised width, shift-in/shift-out, load) is instantiated for RX and TX.

Verification
REQ-042 Write addr 0x0005, data 0xA5, target acks 1 cycle after request -> one target pulse with 0x0005/0xA5, rw=1, then one bus_ack.
REQ-043 Read addr 0x000C, target split_ack then ack 4 cycles later with 0x3C -> bus_split once, serial 0,0,1,1,1,1,0,0, bus_ack in the following cycle.
REQ-044 Address bits with 3-cycle bus_valid gaps -> same address 0x1234 is assembled.
REQ-045 target_ready=0 for 5 cycles in ST_ISSUE -> no request pulse until ready, then exactly one.
REQ-046 Write, no target_ack -> bus_err exactly TIMEOUT cycles after the request pulse, port idle.
REQ-047 rst asserted after 7 address bits -> no target pulse, bus_ready=1, and the next full transaction completes normally.
